// File: rtl/csr_counter_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csr_counter_bank_pkg
// Description : CSR operation encoding, counter/timer CSR addresses and the
//               read-modify-write helper shared by the counter bank.
// Revision    : 1.0 - initial release
// ============================================================================
package csr_counter_bank_pkg;

    // Encoded to match funct3[1:0] of the register CSR instructions
    typedef enum logic [1:0] {
        CSR_OP_CSRRW = 2'b01,
        CSR_OP_CSRRS = 2'b10,
        CSR_OP_CSRRC = 2'b11
    } CsrOp_t;

    localparam logic [11:0] CSR_REG_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_REG_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_REG_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_REG_MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] CSR_REG_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_REG_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_REG_MHPMCOUNTER3H = 12'hB83;
    localparam logic [11:0] CSR_REG_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_REG_TIME          = 12'hC01;
    localparam logic [11:0] CSR_REG_INSTRET       = 12'hC02;
    localparam logic [11:0] CSR_REG_HPMCOUNTER3   = 12'hC03;
    localparam logic [11:0] CSR_REG_CYCLEH        = 12'hC80;
    localparam logic [11:0] CSR_REG_TIMEH         = 12'hC81;
    localparam logic [11:0] CSR_REG_INSTRETH      = 12'hC82;
    localparam logic [11:0] CSR_REG_HPMCOUNTER3H  = 12'hC83;

    function automatic logic [31:0] csr_apply_op(
        input CsrOp_t      op,
        input logic [31:0] old_val,
        input logic [31:0] src
    );
        case (op)
            CSR_OP_CSRRW: return src;
            CSR_OP_CSRRS: return old_val | src;
            CSR_OP_CSRRC: return old_val & ~src;
            default:      return old_val;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_counter_bank_counter.sv
`default_nettype none
// ============================================================================
// Module      : csr_counter
// Description : WIDTH-bit event counter with 32-bit half writes; a write in
//               a cycle suppresses that cycle's increment entirely.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic [31:0]      wdata,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q <= '0;
        end else if (wr_lo) begin
            q[31:0] <= wdata;
        end else if (wr_hi) begin
            q[WIDTH-1:32] <= wdata[WIDTH-33:0];
        end else if (inc) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/csr_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : csr_counter_bank
// Description : RISC-V counter/timer CSRs (mcycle, minstret, mhpmcounters,
//               time, mcountinhibit) with user-mode read-only shadows.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_counter_bank
    import csr_counter_bank_pkg::*;
#(
    parameter int NUM_HPM   = 4,
    parameter int CNT_WIDTH = 64,
    parameter int TIME_DIV  = 1
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 inc_instret,
    input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event,
    input  logic                                 csr_valid,
    input  logic [11:0]                          csr_addr,
    input  CsrOp_t                               csr_op,
    input  logic                                 csr_src_zero,
    input  logic [31:0]                          csr_wdata,
    output logic [31:0]                          csr_rdata,
    output logic                                 csr_illegal
);

    localparam int          c_HPM_W        = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam int          c_PS_W         = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
    localparam logic [31:0] c_INHIBIT_MASK = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);

    logic [CNT_WIDTH-1:0] w_mcycle_q;
    logic [CNT_WIDTH-1:0] w_minstret_q;
    logic [CNT_WIDTH-1:0] w_time_q;
    logic [CNT_WIDTH-1:0] w_hpm_q [c_HPM_W];
    logic [31:0]          r_inhibit;
    logic [c_PS_W-1:0]    r_prescale;

    logic                 w_hi;
    logic [4:0]           w_idx;
    logic                 w_bank_m;
    logic                 w_bank_u;
    logic                 w_mapped;
    logic [CNT_WIDTH-1:0] w_cnt;
    logic                 w_sel_mcycle;
    logic                 w_sel_minstret;
    logic [c_HPM_W-1:0]   w_sel_hpm;
    logic                 w_sel_inhibit;
    logic [31:0]          w_old32;
    logic [31:0]          w_new32;
    logic                 w_write_intent;
    logic                 w_illegal;
    logic                 w_do_write;
    logic                 w_wr_lo;
    logic                 w_wr_hi;
    logic                 w_time_tick;

    // Counter CSRs occupy xx00..xx1F (lo) and xx80..xx9F (hi) of pages B/C
    assign w_hi     = csr_addr[7];
    assign w_idx    = csr_addr[4:0];
    assign w_bank_m = (csr_addr[11:8] == CSR_REG_MCYCLE[11:8]) && (csr_addr[6:5] == 2'b00);
    assign w_bank_u = (csr_addr[11:8] == CSR_REG_CYCLE[11:8])  && (csr_addr[6:5] == 2'b00);

    always_comb begin
        w_mapped       = 1'b0;
        w_cnt          = '0;
        w_sel_mcycle   = 1'b0;
        w_sel_minstret = 1'b0;
        w_sel_hpm      = '0;
        w_sel_inhibit  = 1'b0;
        if (w_bank_m || w_bank_u) begin
            if (w_idx == CSR_REG_MCYCLE[4:0]) begin
                w_mapped     = 1'b1;
                w_cnt        = w_mcycle_q;
                w_sel_mcycle = 1'b1;
            end else if (w_idx == CSR_REG_TIME[4:0]) begin
                w_mapped = w_bank_u;
                w_cnt    = w_time_q;
            end else if (w_idx == CSR_REG_MINSTRET[4:0]) begin
                w_mapped       = 1'b1;
                w_cnt          = w_minstret_q;
                w_sel_minstret = 1'b1;
            end else begin
                for (int i = 0; i < NUM_HPM; i++) begin
                    if (int'(w_idx) == int'(CSR_REG_MHPMCOUNTER3[4:0]) + i) begin
                        w_mapped     = 1'b1;
                        w_cnt        = w_hpm_q[i];
                        w_sel_hpm[i] = 1'b1;
                    end
                end
            end
        end else if (csr_addr == CSR_REG_MCOUNTINHIBIT) begin
            w_mapped      = 1'b1;
            w_sel_inhibit = 1'b1;
        end
    end

    always_comb begin
        w_old32 = w_cnt[31:0];
        if (w_sel_inhibit) begin
            w_old32 = r_inhibit;
        end else if (w_hi) begin
            w_old32 = 32'(w_cnt[CNT_WIDTH-1:32]);
        end
    end

    assign w_new32        = csr_apply_op(csr_op, w_old32, csr_wdata);
    assign w_write_intent = (csr_op == CSR_OP_CSRRW) || !csr_src_zero;
    assign w_illegal      = resetn && csr_valid && (!w_mapped || (w_bank_u && w_write_intent));
    assign w_do_write     = resetn && csr_valid && !w_illegal && w_write_intent;
    assign w_wr_lo        = w_do_write && !w_hi;
    assign w_wr_hi        = w_do_write && w_hi;

    assign csr_illegal = w_illegal;
    assign csr_rdata   = (resetn && csr_valid && !w_illegal) ? w_old32 : 32'h0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_inhibit <= '0;
        end else if (w_wr_lo && w_sel_inhibit) begin
            r_inhibit <= w_new32 & c_INHIBIT_MASK;
        end
    end

    assign w_time_tick = (r_prescale == c_PS_W'(TIME_DIV - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_prescale <= '0;
        end else if (w_time_tick) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + c_PS_W'(1);
        end
    end

    csr_counter #(.WIDTH(CNT_WIDTH)) u_mcycle (
        .clk    (clk),
        .resetn (resetn),
        .inc    (!r_inhibit[0]),
        .wr_lo  (w_wr_lo && w_sel_mcycle),
        .wr_hi  (w_wr_hi && w_sel_mcycle),
        .wdata  (w_new32),
        .q      (w_mcycle_q)
    );

    csr_counter #(.WIDTH(CNT_WIDTH)) u_minstret (
        .clk    (clk),
        .resetn (resetn),
        .inc    (inc_instret && !r_inhibit[2]),
        .wr_lo  (w_wr_lo && w_sel_minstret),
        .wr_hi  (w_wr_hi && w_sel_minstret),
        .wdata  (w_new32),
        .q      (w_minstret_q)
    );

    csr_counter #(.WIDTH(CNT_WIDTH)) u_time (
        .clk    (clk),
        .resetn (resetn),
        .inc    (w_time_tick),
        .wr_lo  (1'b0),
        .wr_hi  (1'b0),
        .wdata  (32'h0),
        .q      (w_time_q)
    );

    generate
        for (genvar gi = 0; gi < NUM_HPM; gi++) begin : g_hpm
            csr_counter #(.WIDTH(CNT_WIDTH)) u_hpm (
                .clk    (clk),
                .resetn (resetn),
                .inc    (hpm_event[gi] && !r_inhibit[3+gi]),
                .wr_lo  (w_wr_lo && w_sel_hpm[gi]),
                .wr_hi  (w_wr_hi && w_sel_hpm[gi]),
                .wdata  (w_new32),
                .q      (w_hpm_q[gi])
            );
        end
        if (NUM_HPM == 0) begin : g_no_hpm
            assign w_hpm_q[0] = '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_csr_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_counter_bank
// Description : Self-checking bench driving two counter-bank configurations
//               (64-bit/TIME_DIV=1 and 40-bit/TIME_DIV=4, both NUM_HPM=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_counter_bank;
    import csr_counter_bank_pkg::*;

    localparam bit Y = 1'b1;
    localparam bit N = 1'b0;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inc_instret;
    logic [1:0]  hpm_event;
    logic        csr_valid;
    logic [11:0] csr_addr;
    CsrOp_t      csr_op;
    logic        csr_src_zero;
    logic [31:0] csr_wdata;
    logic [31:0] rdata_a, rdata_b;
    logic        ill_a, ill_b;

    always #5 clk = ~clk;

    csr_counter_bank #(.NUM_HPM(2), .CNT_WIDTH(64), .TIME_DIV(1)) u_dut_a (
        .clk(clk), .resetn(resetn), .inc_instret(inc_instret), .hpm_event(hpm_event),
        .csr_valid(csr_valid), .csr_addr(csr_addr), .csr_op(csr_op),
        .csr_src_zero(csr_src_zero), .csr_wdata(csr_wdata),
        .csr_rdata(rdata_a), .csr_illegal(ill_a)
    );

    csr_counter_bank #(.NUM_HPM(2), .CNT_WIDTH(40), .TIME_DIV(4)) u_dut_b (
        .clk(clk), .resetn(resetn), .inc_instret(inc_instret), .hpm_event(hpm_event),
        .csr_valid(csr_valid), .csr_addr(csr_addr), .csr_op(csr_op),
        .csr_src_zero(csr_src_zero), .csr_wdata(csr_wdata),
        .csr_rdata(rdata_b), .csr_illegal(ill_b)
    );

    typedef struct {
        bit          v;
        CsrOp_t      op;
        logic [11:0] addr;
        logic [31:0] wd;
        bit          sz;
        bit          inc;
        logic [1:0]  hpm;
        logic [31:0] ea;
        bit          ia;
        logic [31:0] eb;
        bit          ib;
    } vec_t;

    typedef struct {
        bit          chk;
        logic [31:0] ea;
        bit          ia;
        logic [31:0] eb;
        bit          ib;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_edges;

    // Reference for the time CSR: edges seen since reset release
    always @(posedge clk or negedge resetn) begin
        if (!resetn) n_edges <= 0;
        else         n_edges <= n_edges + 1;
    end

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endfunction

    function automatic vec_t mk(input bit v, input CsrOp_t op, input logic [11:0] a,
                                input logic [31:0] wd, input bit sz, input bit inc,
                                input logic [1:0] hpm, input logic [31:0] ea, input bit ia,
                                input logic [31:0] eb, input bit ib);
        vec_t t;
        t.v = v; t.op = op; t.addr = a; t.wd = wd; t.sz = sz; t.inc = inc; t.hpm = hpm;
        t.ea = ea; t.ia = ia; t.eb = eb; t.ib = ib;
        return t;
    endfunction

    task automatic drive(input bit v, input CsrOp_t op, input logic [11:0] a,
                         input logic [31:0] wd, input bit sz, input bit inc, input logic [1:0] hpm);
        csr_valid    = v;
        csr_op       = op;
        csr_addr     = a;
        csr_wdata    = wd;
        csr_src_zero = sz;
        inc_instret  = inc;
        hpm_event    = hpm;
    endtask

    task automatic access(input vec_t t, input bit chk, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        drive(t.v, t.op, t.addr, t.wd, t.sz, t.inc, t.hpm);
        sb.push_back('{chk, t.ea, t.ia, t.eb, t.ib});
        @(negedge clk);
        e = sb.pop_front();
        if (e.chk) begin
            check({nm, "/rdata_a"}, rdata_a, e.ea);
            check({nm, "/rdata_b"}, rdata_b, e.eb);
        end
        check({nm, "/illegal_a"}, 32'(ill_a), 32'(e.ia));
        check({nm, "/illegal_b"}, 32'(ill_b), 32'(e.ib));
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] ea, input logic [31:0] eb, input string nm);
        access(mk(Y, CSR_OP_CSRRS, a, 32'h0, Y, N, 2'b00, ea, N, eb, N), Y, nm);
    endtask

    task automatic wr(input CsrOp_t op, input logic [11:0] a, input logic [31:0] wd, input string nm);
        access(mk(Y, op, a, wd, N, N, 2'b00, 32'h0, N, 32'h0, N), N, nm);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        drive(N, CSR_OP_CSRRS, 12'h000, 32'h0, Y, N, 2'b00);
    endtask

    initial begin
        // Illegal write presented during reset must not show up on the outputs
        resetn = 1'b0;
        drive(Y, CSR_OP_CSRRW, 12'hC00, 32'h5, N, Y, 2'b11);
        #12;
        check("reset/rdata_a", rdata_a, 32'h0);
        check("reset/illegal_a", 32'(ill_a), 32'h0);
        check("reset/rdata_b", rdata_b, 32'h0);
        check("reset/illegal_b", 32'(ill_b), 32'h0);
        @(negedge clk);
        drive(N, CSR_OP_CSRRS, 12'h000, 32'h0, Y, N, 2'b00);
        resetn = 1'b1;

        repeat (9) @(posedge clk);
        rd(12'hC00, 32'd10, 32'd10, "cycle_after_10");
        rd(12'hC80, 32'd0,  32'd0,  "cycleh_after_11");
        rd(12'hC01, 32'd12, 32'd3,  "time_after_12");
        rd(12'hC02, 32'd0,  32'd0,  "instret_idle");

        vecs.push_back(mk(Y, CSR_OP_CSRRS, 12'hB05, 32'h0, Y, N, 2'b00, 32'h0, Y, 32'h0, Y));
        vecs.push_back(mk(Y, CSR_OP_CSRRS, 12'hB04, 32'h0, Y, N, 2'b00, 32'h0, N, 32'h0, N));
        vecs.push_back(mk(Y, CSR_OP_CSRRS, 12'hC05, 32'h0, Y, N, 2'b00, 32'h0, Y, 32'h0, Y));
        vecs.push_back(mk(Y, CSR_OP_CSRRS, 12'hC84, 32'h0, Y, N, 2'b00, 32'h0, N, 32'h0, N));
        vecs.push_back(mk(Y, CSR_OP_CSRRS, 12'hB01, 32'h0, Y, N, 2'b00, 32'h0, Y, 32'h0, Y));
        vecs.push_back(mk(Y, CSR_OP_CSRRS, 12'hB20, 32'h0, Y, N, 2'b00, 32'h0, Y, 32'h0, Y));
        vecs.push_back(mk(Y, CSR_OP_CSRRS, 12'h321, 32'h0, Y, N, 2'b00, 32'h0, Y, 32'h0, Y));
        vecs.push_back(mk(Y, CSR_OP_CSRRS, 12'h320, 32'h0, Y, N, 2'b00, 32'h0, N, 32'h0, N));
        vecs.push_back(mk(Y, CSR_OP_CSRRW, 12'hC04, 32'h1, N, N, 2'b00, 32'h0, Y, 32'h0, Y));
        vecs.push_back(mk(Y, CSR_OP_CSRRS, 12'hC04, 32'h0, N, N, 2'b00, 32'h0, Y, 32'h0, Y));
        vecs.push_back(mk(Y, CSR_OP_CSRRW, 12'hB04, 32'h1234, N, N, 2'b00, 32'h0, N, 32'h0, N));
        vecs.push_back(mk(Y, CSR_OP_CSRRS, 12'hC04, 32'h0, Y, N, 2'b00, 32'h1234, N, 32'h1234, N));
        vecs.push_back(mk(Y, CSR_OP_CSRRC, 12'hB04, 32'h4, N, N, 2'b00, 32'h1234, N, 32'h1234, N));
        vecs.push_back(mk(Y, CSR_OP_CSRRS, 12'hB04, 32'h0, Y, N, 2'b00, 32'h1230, N, 32'h1230, N));
        vecs.push_back(mk(Y, CSR_OP_CSRRS, 12'hB04, 32'hF, Y, N, 2'b00, 32'h1230, N, 32'h1230, N));
        vecs.push_back(mk(Y, CSR_OP_CSRRS, 12'hB04, 32'h0, Y, N, 2'b00, 32'h1230, N, 32'h1230, N));
        vecs.push_back(mk(Y, CSR_OP_CSRRS, 12'hB84, 32'hFFFFFFFF, N, N, 2'b00, 32'h0, N, 32'h0, N));
        vecs.push_back(mk(Y, CSR_OP_CSRRS, 12'hC84, 32'h0, Y, N, 2'b00, 32'hFFFFFFFF, N, 32'h000000FF, N));
        vecs.push_back(mk(Y, CSR_OP_CSRRW, 12'hB03, 32'h7, N, N, 2'b00, 32'h0, N, 32'h0, N));
        vecs.push_back(mk(Y, CSR_OP_CSRRS, 12'hB03, 32'h0, Y, N, 2'b01, 32'h7, N, 32'h7, N));
        vecs.push_back(mk(Y, CSR_OP_CSRRS, 12'hB03, 32'h0, Y, N, 2'b00, 32'h8, N, 32'h8, N));
        vecs.push_back(mk(Y, CSR_OP_CSRRW, 12'hB03, 32'h64, N, N, 2'b01, 32'h8, N, 32'h8, N));
        vecs.push_back(mk(Y, CSR_OP_CSRRS, 12'hB03, 32'h0, Y, N, 2'b00, 32'h64, N, 32'h64, N));
        vecs.push_back(mk(Y, CSR_OP_CSRRS, 12'hB04, 32'h0, Y, N, 2'b10, 32'h1230, N, 32'h1230, N));
        vecs.push_back(mk(Y, CSR_OP_CSRRS, 12'hB04, 32'h0, Y, N, 2'b00, 32'h1231, N, 32'h1231, N));
        vecs.push_back(mk(Y, CSR_OP_CSRRW, 12'hB02, 32'h5, N, Y, 2'b00, 32'h0, N, 32'h0, N));
        vecs.push_back(mk(Y, CSR_OP_CSRRS, 12'hC02, 32'h0, Y, N, 2'b00, 32'h5, N, 32'h5, N));
        vecs.push_back(mk(Y, CSR_OP_CSRRS, 12'hB02, 32'hFF, Y, N, 2'b00, 32'h5, N, 32'h5, N));
        vecs.push_back(mk(Y, CSR_OP_CSRRS, 12'hC02, 32'h0, Y, Y, 2'b00, 32'h5, N, 32'h5, N));
        vecs.push_back(mk(Y, CSR_OP_CSRRS, 12'hC02, 32'h0, Y, N, 2'b00, 32'h6, N, 32'h6, N));
        vecs.push_back(mk(Y, CSR_OP_CSRRS, 12'h320, 32'h4, N, N, 2'b00, 32'h0, N, 32'h0, N));
        vecs.push_back(mk(Y, CSR_OP_CSRRS, 12'hC02, 32'h0, Y, Y, 2'b00, 32'h6, N, 32'h6, N));
        vecs.push_back(mk(Y, CSR_OP_CSRRS, 12'hC02, 32'h0, Y, N, 2'b00, 32'h6, N, 32'h6, N));
        vecs.push_back(mk(Y, CSR_OP_CSRRW, 12'h320, 32'hFFFFFFFF, N, N, 2'b00, 32'h4, N, 32'h4, N));
        vecs.push_back(mk(Y, CSR_OP_CSRRW, 12'h320, 32'h0, N, N, 2'b00, 32'h1D, N, 32'h1D, N));
        vecs.push_back(mk(Y, CSR_OP_CSRRS, 12'h320, 32'h0, Y, N, 2'b00, 32'h0, N, 32'h0, N));
        vecs.push_back(mk(Y, CSR_OP_CSRRS, 12'hC82, 32'h0, Y, N, 2'b00, 32'h0, N, 32'h0, N));
        vecs.push_back(mk(N, CSR_OP_CSRRS, 12'hB05, 32'h0, Y, N, 2'b00, 32'h0, N, 32'h0, N));
        vecs.push_back(mk(N, CSR_OP_CSRRW, 12'hB04, 32'h0, N, N, 2'b00, 32'h0, N, 32'h0, N));
        vecs.push_back(mk(Y, CSR_OP_CSRRS, 12'hB04, 32'h0, Y, N, 2'b00, 32'h1231, N, 32'h1231, N));
        vecs.push_back(mk(Y, CSR_OP_CSRRS, 12'hC81, 32'h0, Y, N, 2'b00, 32'h0, N, 32'h0, N));

        foreach (vecs[i]) access(vecs[i], Y, $sformatf("vec%0d", i));

        // Carry from lo into hi
        wr(CSR_OP_CSRRW, 12'hB80, 32'h0, "carry/clr_hi");
        wr(CSR_OP_CSRRW, 12'hB00, 32'hFFFFFFFF, "carry/set_lo");
        idle();
        rd(12'hB00, 32'h0, 32'h0, "carry/lo");
        rd(12'hB80, 32'h1, 32'h1, "carry/hi");

        // Hi write truncation and full-width wrap to zero
        wr(CSR_OP_CSRRW, 12'hB80, 32'hFFFFFFFF, "wrap/set_hi");
        rd(12'hB80, 32'hFFFFFFFF, 32'h000000FF, "wrap/hi_trunc");
        wr(CSR_OP_CSRRW, 12'hB00, 32'hFFFFFFFF, "wrap/set_lo");
        rd(12'hB80, 32'hFFFFFFFF, 32'h000000FF, "wrap/hi_before");
        rd(12'hB00, 32'h0, 32'h0, "wrap/lo_after");
        rd(12'hB80, 32'h0, 32'h0, "wrap/hi_after");

        // Hi write while lo is all-ones: no carry in the write cycle
        wr(CSR_OP_CSRRW, 12'hB00, 32'hFFFFFFFF, "nocarry/set_lo");
        wr(CSR_OP_CSRRW, 12'hB80, 32'h7, "nocarry/set_hi");
        rd(12'hB00, 32'hFFFFFFFF, 32'hFFFFFFFF, "nocarry/lo_held");
        rd(12'hB80, 32'h8, 32'h8, "nocarry/hi_carried");

        // Cycle inhibit, illegal shadow write, and inhibit timing
        wr(CSR_OP_CSRRW, 12'hB80, 32'h0, "inh/clr_hi");
        wr(CSR_OP_CSRRW, 12'hB00, 32'h0, "inh/clr_lo");
        access(mk(Y, CSR_OP_CSRRS, 12'h320, 32'h1, N, N, 2'b00, 32'h0, N, 32'h0, N), Y, "inh/set");
        rd(12'hC00, 32'h1, 32'h1, "inh/start");
        rd(12'hC01, 32'(n_edges + 1), 32'((n_edges + 1) / 4), "inh/time_before");
        repeat (18) idle();
        rd(12'hC01, 32'(n_edges + 1), 32'((n_edges + 1) / 4), "inh/time_after");
        rd(12'hB00, 32'h1, 32'h1, "inh/mcycle_held");
        access(mk(Y, CSR_OP_CSRRW, 12'hC00, 32'h55, N, N, 2'b00, 32'h0, Y, 32'h0, Y), Y, "illegal_wr_c00");
        rd(12'hC00, 32'h1, 32'h1, "c00_unaffected");
        rd(12'h320, 32'h1, 32'h1, "inh/readback");
        access(mk(Y, CSR_OP_CSRRC, 12'h320, 32'h1, N, N, 2'b00, 32'h1, N, 32'h1, N), Y, "inh/clr");
        rd(12'hC00, 32'h1, 32'h1, "inh/clr_cycle");
        rd(12'hC00, 32'h2, 32'h2, "inh/resumed");

        // Reset asserted while a write is pending
        @(posedge clk);
        #1;
        drive(Y, CSR_OP_CSRRW, 12'hB04, 32'hABCD, N, N, 2'b00);
        #2;
        resetn = 1'b0;
        #1;
        check("midreset/rdata_a", rdata_a, 32'h0);
        check("midreset/illegal_a", 32'(ill_a), 32'h0);
        check("midreset/rdata_b", rdata_b, 32'h0);
        @(posedge clk);
        #1;
        drive(N, CSR_OP_CSRRS, 12'h000, 32'h0, Y, N, 2'b00);
        @(negedge clk);
        resetn = 1'b1;
        rd(12'hC00, 32'h1, 32'h1, "midreset/cycle");
        rd(12'hB04, 32'h0, 32'h0, "midreset/write_discarded");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
